// File: rtl/seven_seg_scan_ctrl.sv
// Purpose : time-multiplexed scan controller for a 4-digit seven-segment display, with a double-buffered value.
// Latency : every output is registered; a load is visible one cycle after its commit edge.
// Backpr. : none; loads made while scanning are held in a shadow buffer until the next frame boundary.
//
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   scan_en      1 = scan the digits, 0 = display dark and idle
//   digit_en     per-digit enable (bit i = digit i)
//   load         single-cycle request to display load_value
//   load_value   value to display; nibble i goes to digit i
//   load_ack     one-cycle pulse when a load reaches the active value
//   digit_sel    active-low one-hot digit select (4'b1111 = all off)
//   nibble       active value nibble for the current digit index
//   frame_tick   one-cycle pulse after each completed 4-digit frame
module seven_seg_scan_ctrl #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scan_en,
  input  logic [3:0]  digit_en,
  input  logic        load,
  input  logic [15:0] load_value,
  output logic        load_ack,
  output logic [3:0]  digit_sel,
  output logic [3:0]  nibble,
  output logic        frame_tick
);

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  localparam int              CW        = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0]   SLOT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0]   BLANK_END = CW'(BLANK_CYCLES);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0]    idx, idx_nxt;
  logic [15:0]   active, active_nxt;
  logic [15:0]   shadow, shadow_nxt;
  logic          pending, pending_nxt;
  logic          commit, frame_end, slot_end;

  logic [3:0]    digit_sel_nxt;
  logic [3:0]    nibble_nxt;

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= 2'd0;
      active     <= 16'h0000;
      shadow     <= 16'h0000;
      pending    <= 1'b0;
      digit_sel  <= 4'hF;
      nibble     <= 4'h0;
      load_ack   <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      idx        <= idx_nxt;
      active     <= active_nxt;
      shadow     <= shadow_nxt;
      pending    <= pending_nxt;
      digit_sel  <= digit_sel_nxt;
      nibble     <= nibble_nxt;
      load_ack   <= commit;
      frame_tick <= frame_end;
    end
  end

  // Next-state: slot timing, digit index, and the shadow/active buffer.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    idx_nxt     = idx;
    active_nxt  = active;
    shadow_nxt  = shadow;
    pending_nxt = pending;
    commit      = 1'b0;
    frame_end   = 1'b0;
    slot_end    = (cnt == SLOT_LAST);

    case (state)
      IDLE: begin
        // Nothing is on screen, so a load can go straight to the active value.
        if (load) begin
          active_nxt = load_value;
          commit     = 1'b1;
        end
        if (scan_en) begin
          state_nxt = BLANK;
          cnt_nxt   = '0;
          idx_nxt   = 2'd0;
        end
      end

      BLANK, SHOW: begin
        if (!scan_en) begin
          // Going dark: flush whatever is waiting, newest request first.
          state_nxt   = IDLE;
          cnt_nxt     = '0;
          idx_nxt     = 2'd0;
          pending_nxt = 1'b0;
          if (load) begin
            active_nxt = load_value;
            commit     = 1'b1;
          end else if (pending) begin
            active_nxt = shadow;
            commit     = 1'b1;
          end
        end else begin
          cnt_nxt   = slot_end ? '0 : cnt + CW'(1);
          idx_nxt   = slot_end ? idx + 2'd1 : idx;
          state_nxt = (cnt_nxt < BLANK_END) ? BLANK : SHOW;
          if (slot_end && idx == 2'd3) begin
            // Frame boundary: the only point where the active value may change,
            // so no digit of a frame is drawn from a different value.
            frame_end   = 1'b1;
            pending_nxt = 1'b0;
            if (load) begin
              active_nxt = load_value;
              commit     = 1'b1;
            end else if (pending) begin
              active_nxt = shadow;
              commit     = 1'b1;
            end
          end else if (load) begin
            shadow_nxt  = load_value;
            pending_nxt = 1'b1;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        idx_nxt   = 2'd0;
      end
    endcase
  end

  // Output decode from next-state values so the registered outputs line up
  // with the state they describe.
  always_comb begin
    digit_sel_nxt = 4'hF;
    if (state_nxt == SHOW && digit_en[idx_nxt])
      digit_sel_nxt = ~(4'b0001 << idx_nxt);
    nibble_nxt = active_nxt[{idx_nxt, 2'b00} +: 4];
  end

endmodule
